// File: rtl/sha_pkg.sv
// Shared constants, FSM encoding and block-assembly helpers for the SHA-256 message padder.
// Pure definitions: no latency, no flow control.
// Bytes are big-endian within a 512-bit block, byte 0 in bits [511:504].
package sha_pkg;

    localparam int         BLOCK_BYTES = 64;
    localparam int         LEN_BYTES   = 8;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        FILL,
        HOLD,
        LENBLK
    } pad_state_t;

    function automatic logic [511:0] put_byte(input logic [511:0] blk,
                                              input logic [5:0]   p,
                                              input logic [7:0]   b);
        logic [511:0] r;
        r = blk;
        r[511 - 8 * int'(p) -: 8] = b;
        return r;
    endfunction

    // Trailing pad-only block; carries the 0x80 marker when the data ended exactly on a block boundary.
    function automatic logic [511:0] len_block(input logic [63:0] bitlen, input logic pad80);
        return {(pad80 ? PAD_BYTE : 8'h00), 440'b0, bitlen};
    endfunction

endpackage

// File: rtl/sha_gap_timer.sv
// Spacing timer between chained blocks: reloads CHAIN_GAP-1 on strobe, counts down to zero.
// Latency: expired rises CHAIN_GAP-1 cycles after the strobe cycle, so an emit decided then lands CHAIN_GAP after.
// No flow control; strobe is sampled every cycle.
module sha_gap_timer #(
    parameter int CHAIN_GAP = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic expired
);

    localparam int CW = $clog2(CHAIN_GAP + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (strobe) begin
            cnt_d = CW'(CHAIN_GAP - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/sha_msg_padder.sv
// Byte stream -> SHA-256 padded 512-bit blocks, chained blocks spaced CHAIN_GAP apart (SHA_PAD_MSGCNT_EN adds msg_count).
// Latency: a completed block strobes one cycle after its last byte is accepted unless the chain gap is still running.
// Backpressure: s_ready drops while a block waits on the gap, during a pending pad block and on the final strobe cycle.
module sha_msg_padder
    import sha_pkg::*;
#(
    parameter int CHAIN_GAP = 64,
    parameter int LEN_W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [7:0]   s_data,
    input  logic         s_last,
    output logic         blk_valid,
    output logic         blk_first,
    output logic         blk_last,
    output logic [511:0] block
`ifdef SHA_PAD_MSGCNT_EN
    ,
    output logic [15:0]  msg_count
`endif
);

    pad_state_t       state_q, state_d;
    logic [5:0]       pos_q, pos_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [511:0]     buf_q, buf_d;
    logic [511:0]     block_q, block_d;
    logic             blk_valid_q, blk_valid_d;
    logic             blk_first_q, blk_first_d;
    logic             blk_last_q, blk_last_d;
    logic             mid_msg_q, mid_msg_d;
    logic             hold_last_q, hold_last_d;
    logic             len_pend_q, len_pend_d;
    logic             pad80_q, pad80_d;

    logic             gap_expired;
    logic             gap_ok;
    logic             accept;
    logic             tail_last;
    logic [LEN_W-1:0] len_inc;
    logic [511:0]     filled;
    logic [511:0]     cand;

    sha_gap_timer #(.CHAIN_GAP(CHAIN_GAP)) u_gap (
        .clk     (clk),
        .reset   (reset),
        .strobe  (blk_valid_d),
        .expired (gap_expired)
    );

    assign s_ready = (state_q == FILL) && !reset && !(blk_valid_q && blk_last_q);
    assign accept  = s_valid && s_ready;
    // The first block of a message starts an independent hash, so only later blocks wait on the gap.
    assign gap_ok  = !mid_msg_q || gap_expired;
    assign len_inc = len_q + LEN_W'(1);
    assign filled  = put_byte(buf_q, pos_q, s_data);

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        len_d       = len_q;
        buf_d       = buf_q;
        block_d     = block_q;
        blk_valid_d = 1'b0;
        blk_first_d = 1'b0;
        blk_last_d  = 1'b0;
        mid_msg_d   = mid_msg_q;
        hold_last_d = hold_last_q;
        len_pend_d  = len_pend_q;
        pad80_d     = pad80_q;
        tail_last   = 1'b0;
        cand        = filled;

        case (state_q)
            FILL: begin
                if (accept) begin
                    len_d = len_inc;
                    pos_d = pos_q + 6'd1;
                    if (!s_last) begin
                        buf_d = filled;
                        if (pos_q == 6'(BLOCK_BYTES - 1)) begin
                            hold_last_d = 1'b0;
                            len_pend_d  = 1'b0;
                            if (gap_ok) begin
                                blk_valid_d = 1'b1;
                                blk_first_d = !mid_msg_q;
                                block_d     = filled;
                                buf_d       = '0;
                                mid_msg_d   = 1'b1;
                            end else begin
                                state_d = HOLD;
                            end
                        end
                    end else begin
                        tail_last = (pos_q <= 6'(BLOCK_BYTES - LEN_BYTES - 2));
                        if (pos_q != 6'(BLOCK_BYTES - 1)) begin
                            cand = put_byte(filled, pos_q + 6'd1, PAD_BYTE);
                        end
                        if (tail_last) begin
                            cand[63:0] = {{(61 - LEN_W){1'b0}}, len_inc, 3'b000};
                        end
                        hold_last_d = tail_last;
                        len_pend_d  = !tail_last;
                        pad80_d     = (pos_q == 6'(BLOCK_BYTES - 1));
                        if (gap_ok) begin
                            blk_valid_d = 1'b1;
                            blk_first_d = !mid_msg_q;
                            blk_last_d  = tail_last;
                            block_d     = cand;
                            buf_d       = '0;
                            if (tail_last) begin
                                pos_d     = '0;
                                len_d     = '0;
                                mid_msg_d = 1'b0;
                            end else begin
                                mid_msg_d = 1'b1;
                                state_d   = LENBLK;
                            end
                        end else begin
                            buf_d   = cand;
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (gap_ok) begin
                    blk_valid_d = 1'b1;
                    blk_first_d = !mid_msg_q;
                    blk_last_d  = hold_last_q;
                    block_d     = buf_q;
                    buf_d       = '0;
                    if (hold_last_q) begin
                        pos_d     = '0;
                        len_d     = '0;
                        mid_msg_d = 1'b0;
                        state_d   = FILL;
                    end else begin
                        mid_msg_d = 1'b1;
                        state_d   = len_pend_q ? LENBLK : FILL;
                    end
                end
            end
            LENBLK: begin
                if (gap_ok) begin
                    blk_valid_d = 1'b1;
                    blk_first_d = !mid_msg_q;
                    blk_last_d  = 1'b1;
                    block_d     = len_block({{(61 - LEN_W){1'b0}}, len_q, 3'b000}, pad80_q);
                    pos_d       = '0;
                    len_d       = '0;
                    mid_msg_d   = 1'b0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            pos_q       <= '0;
            len_q       <= '0;
            buf_q       <= '0;
            block_q     <= '0;
            blk_valid_q <= 1'b0;
            blk_first_q <= 1'b0;
            blk_last_q  <= 1'b0;
            mid_msg_q   <= 1'b0;
            hold_last_q <= 1'b0;
            len_pend_q  <= 1'b0;
            pad80_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            len_q       <= len_d;
            buf_q       <= buf_d;
            block_q     <= block_d;
            blk_valid_q <= blk_valid_d;
            blk_first_q <= blk_first_d;
            blk_last_q  <= blk_last_d;
            mid_msg_q   <= mid_msg_d;
            hold_last_q <= hold_last_d;
            len_pend_q  <= len_pend_d;
            pad80_q     <= pad80_d;
        end
    end

    assign blk_valid = blk_valid_q;
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;
    assign block     = block_q;

`ifdef SHA_PAD_MSGCNT_EN
    logic [15:0] msg_cnt_q, msg_cnt_d;

    always_comb begin
        msg_cnt_d = msg_cnt_q + {15'd0, (blk_valid_d && blk_last_d)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            msg_cnt_q <= '0;
        end else begin
            msg_cnt_q <= msg_cnt_d;
        end
    end

    assign msg_count = msg_cnt_q;
`endif

endmodule

// File: tb/tb_sha_msg_padder.sv
// Bench for sha_msg_padder: randomized byte streams against a whole-message SHA-256 padding model.
module tb_sha_msg_padder;

    localparam int GAP = 64;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [511:0] blk;
        bit           first;
        bit           last;
        int           ready;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         s_last;
    logic         blk_valid;
    logic         blk_first;
    logic         blk_last;
    logic [511:0] block;
`ifdef SHA_PAD_MSGCNT_EN
    logic [15:0]  msg_count;
`endif

    sha_msg_padder #(.CHAIN_GAP(GAP), .LEN_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .blk_valid (blk_valid),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .block     (block)
`ifdef SHA_PAD_MSGCNT_EN
        ,
        .msg_count (msg_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Model state
    exp_t         exp_q[$];
    logic [7:0]   cur[$];
    int           nblk      = 0;
    int           cyc       = 0;
    int           last_stb  = -100000;
    logic [511:0] last_blk  = '0;
    bit           rst_prev  = 1'b0;
    int           model_cnt = 0;

    // Strobe capture for the directed checks
    logic [511:0] cap_blk[$];
    bit           cap_first[$];
    bit           cap_last[$];
    int           cap_cyc[$];

    function automatic logic [511:0] pack_blk(input logic [7:0] b[$], input int k);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) r[511 - 8 * i -: 8] = b[64 * k + i];
        return r;
    endfunction

    function automatic int due_of(input exp_t e, input int prev);
        int w;
        w = e.ready;
        if (!e.first && prev + GAP > w) w = prev + GAP;
        return w;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            chk("rst_s_ready", {511'b0, s_ready}, 512'd0);
            if (rst_prev) begin
                chk("rst_blk_valid", {511'b0, blk_valid}, 512'd0);
                chk("rst_block", block, 512'd0);
            end
            exp_q.delete();
            cur.delete();
            nblk      = 0;
            last_blk  = '0;
            last_stb  = -100000;
            model_cnt = 0;
            rst_prev  = 1'b1;
        end else begin
            rst_prev = 1'b0;
            if (blk_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {511'b0, blk_valid}, 512'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_cycle", 512'(cyc), 512'(due_of(e, last_stb)));
                    chk("block", block, e.blk);
                    chk("blk_first", {511'b0, blk_first}, {511'b0, e.first});
                    chk("blk_last", {511'b0, blk_last}, {511'b0, e.last});
                    if (e.last) model_cnt = (model_cnt + 1) % 65536;
                end
                last_stb = cyc;
                last_blk = block;
                cap_blk.push_back(block);
                cap_first.push_back(blk_first);
                cap_last.push_back(blk_last);
                cap_cyc.push_back(cyc);
            end else begin
                chk("block_hold", block, last_blk);
                if (exp_q.size() > 0 && cyc > due_of(exp_q[0], last_stb)) begin
                    chk("missed_strobe", {511'b0, blk_valid}, 512'd1);
                    void'(exp_q.pop_front());
                end
            end
`ifdef SHA_PAD_MSGCNT_EN
            chk("msg_count", {496'b0, msg_count}, 512'(model_cnt));
`endif
            chk("s_ready", {511'b0, s_ready},
                {511'b0, (exp_q.size() == 0) && !(blk_valid && blk_last)});
            if (s_valid && s_ready) begin
                cur.push_back(s_data);
                if (!s_last) begin
                    if (cur.size() % 64 == 0) begin
                        exp_q.push_back('{pack_blk(cur, nblk), nblk == 0, 1'b0, cyc + 1});
                        nblk++;
                    end
                end else begin
                    logic [7:0] p[$];
                    logic [63:0] bl;
                    int total;
                    p  = cur;
                    bl = 64'(cur.size()) * 64'd8;
                    p.push_back(8'h80);
                    while (p.size() % 64 != 56) p.push_back(8'h00);
                    for (int i = 7; i >= 0; i--) p.push_back(bl[8 * i +: 8]);
                    total = p.size() / 64;
                    for (int k = nblk; k < total; k++)
                        exp_q.push_back('{pack_blk(p, k), k == 0, k == total - 1, cyc + 1});
                    cur.delete();
                    nblk = 0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit last, input int prob);
        bit acc;
        int guard;
        while ($urandom_range(99) >= prob) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        guard   = 0;
        acc     = 1'b0;
        while (!acc && guard < 500) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!acc) chk("accept_timeout", 512'd0, 512'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_msg(input bq_t msg, input int prob);
        for (int i = 0; i < msg.size(); i++) send_byte(msg[i], i == msg.size() - 1, prob);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 1000) begin
            @(posedge clk); #1;
            g++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 512'(exp_q.size()), 512'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_cap();
        cap_blk.delete();
        cap_first.delete();
        cap_last.delete();
        cap_cyc.delete();
    endtask

    bq_t          msg;
    logic [511:0] abc_blk;

    initial begin
        abc_blk = {32'h61626380, 416'h0, 64'h18};
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // 1: "abc"
        clear_cap();
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(msg, 100);
        wait_idle();
        chk("t1_count", 512'(cap_blk.size()), 512'd1);
        if (cap_blk.size() == 1) begin
            chk("t1_block", cap_blk[0], abc_blk);
            chk("t1_flags", {510'b0, cap_first[0], cap_last[0]}, 512'd3);
        end

        // 2: 56-byte two-block message
        clear_cap();
        msg.delete();
        for (int i = 0; i < 14; i++)
            for (int j = 0; j < 4; j++) msg.push_back(8'(8'h61 + i + j));
        send_msg(msg, 100);
        wait_idle();
        chk("t2_count", 512'(cap_blk.size()), 512'd2);
        if (cap_blk.size() == 2) begin
            chk("t2_blk0_tail", {416'b0, cap_blk[0][95:0]}, {416'b0, 96'h6E6F7071_80000000_00000000});
            chk("t2_blk0_flags", {510'b0, cap_first[0], cap_last[0]}, 512'd2);
            chk("t2_blk1", cap_blk[1], {448'b0, 64'h1C0});
            chk("t2_gap", 512'(cap_cyc[1] - cap_cyc[0]), 512'(GAP));
        end

        // 3: 64 zero bytes
        clear_cap();
        msg.delete();
        for (int i = 0; i < 64; i++) msg.push_back(8'h00);
        send_msg(msg, 100);
        wait_idle();
        chk("t3_count", 512'(cap_blk.size()), 512'd2);
        if (cap_blk.size() == 2) begin
            chk("t3_blk0", cap_blk[0], 512'd0);
            chk("t3_blk1", cap_blk[1], {32'h80000000, 416'h0, 64'h200});
            chk("t3_gap", 512'(cap_cyc[1] - cap_cyc[0]), 512'(GAP));
        end

        // 4: 130 random bytes, 50% valid
        clear_cap();
        msg.delete();
        for (int i = 0; i < 130; i++) msg.push_back(8'($urandom));
        send_msg(msg, 50);
        wait_idle();
        chk("t4_count", 512'(cap_blk.size()), 512'd3);
        if (cap_blk.size() == 3) begin
            chk("t4_bitlen", {448'b0, cap_blk[2][63:0]}, {448'b0, 64'h410});
            chk("t4_gap01_ok", {511'b0, (cap_cyc[1] - cap_cyc[0]) >= GAP}, 512'd1);
            chk("t4_gap12_ok", {511'b0, (cap_cyc[2] - cap_cyc[1]) >= GAP}, 512'd1);
        end

        // 5: reset in the middle of a message
        msg.delete();
        for (int i = 0; i < 30; i++) msg.push_back(8'($urandom));
        for (int i = 0; i < 30; i++) send_byte(msg[i], 1'b0, 100);
        do_reset();
        clear_cap();
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(msg, 100);
        wait_idle();
        chk("t5_count", 512'(cap_blk.size()), 512'd1);
        if (cap_blk.size() == 1) begin
            chk("t5_block", cap_blk[0], abc_blk);
            chk("t5_first", {511'b0, cap_first[0]}, 512'd1);
        end

        // 6: back-to-back "abc" twice
        do_reset();
        clear_cap();
        send_msg(msg, 100);
        send_msg(msg, 100);
        wait_idle();
        chk("t6_count", 512'(cap_blk.size()), 512'd2);
        if (cap_blk.size() == 2)
            chk("t6_spacing", 512'(cap_cyc[1] - cap_cyc[0]), 512'd4);
`ifdef SHA_PAD_MSGCNT_EN
        chk("t6_msg_count", {496'b0, msg_count}, 512'd2);
`endif

        // Boundary lengths and random lengths with random valid density
        for (int r = 0; r < 16; r++) begin
            int len;
            int lens[10] = '{1, 55, 56, 63, 64, 65, 119, 120, 127, 128};
            len = (r < 10) ? lens[r] : int'($urandom_range(1, 150));
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            send_msg(msg, int'($urandom_range(30, 100)));
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

endmodule
